// File: rtl/snax_exercise_bias_pe.sv
`default_nettype none
// ============================================================================
// Module   : snax_exercise_bias_pe
// Purpose  : Two-stage valid/ready bias-add PE between the read and write
//            streamers. The 64-bit bias snapshot is taken with each word.
//            Optional macro SNAX_EXERCISE_BIAS_PE_SAT_EN makes the add
//            unsigned-saturating instead of wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module snax_exercise_bias_pe #(
   parameter int RegDataWidth = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      acc_ready_i,
   input  logic [RegDataWidth-1:0]   csr_upper_bias_i,
   input  logic [RegDataWidth-1:0]   csr_lower_bias_i,
   input  logic [2*RegDataWidth-1:0] in_data_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [2*RegDataWidth-1:0] out_data_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      acc_output_success_o,
   output logic                      pe_idle_o
);

   localparam int DATA_W = 2 * RegDataWidth;

   logic              s1_valid;
   logic              s2_valid;
   logic [DATA_W-1:0] s1_data;
   logic [DATA_W-1:0] s1_bias;
   logic [DATA_W-1:0] s2_data;
   logic [DATA_W-1:0] sum;
   logic              s1_adv;
   logic              s2_adv;
   logic              in_fire;
   logic              s1_move;

   assign s2_adv     = !s2_valid || out_ready_i;
   assign s1_adv     = !s1_valid || s2_adv;
   assign in_ready_o = acc_ready_i && s1_adv;
   assign in_fire    = in_valid_i && in_ready_o;
   assign s1_move    = s1_valid && s2_adv;

`ifdef SNAX_EXERCISE_BIAS_PE_SAT_EN
   logic [DATA_W:0] sum_full;

   assign sum_full = {1'b0, s1_data} + {1'b0, s1_bias};
   assign sum      = sum_full[DATA_W] ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
   assign sum = s1_data + s1_bias;
`endif

   // Stage 1: operand plus the bias in force on the cycle it was accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_bias  <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_data  <= in_data_i;
         s1_bias  <= {csr_upper_bias_i, csr_lower_bias_i};
      end else if (s1_move) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2 only loads when it is free or being drained, so a stalled
   // result holds its value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else if (s1_move) begin
         s2_valid <= 1'b1;
         s2_data  <= sum;
      end else if (out_ready_i) begin
         s2_valid <= 1'b0;
      end
   end

   assign out_data_o           = s2_data;
   assign out_valid_o          = s2_valid;
   assign acc_output_success_o = s2_valid && out_ready_i;
   assign pe_idle_o            = !s1_valid && !s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_snax_exercise_bias_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_snax_exercise_bias_pe
// Purpose  : Directed, table-driven bench for snax_exercise_bias_pe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_exercise_bias_pe;

   localparam int W = 32;

   logic            clk;
   logic            rst;
   logic            acc_ready;
   logic [W-1:0]    upper_bias;
   logic [W-1:0]    lower_bias;
   logic [2*W-1:0]  in_data;
   logic            in_valid;
   logic            in_ready;
   logic [2*W-1:0]  out_data;
   logic            out_valid;
   logic            out_ready;
   logic            success;
   logic            pe_idle;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   logic [2*W-1:0] out_q[$];
   int             out_cyc[$];

   snax_exercise_bias_pe #(.RegDataWidth(W)) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .acc_ready_i          (acc_ready),
      .csr_upper_bias_i     (upper_bias),
      .csr_lower_bias_i     (lower_bias),
      .in_data_i            (in_data),
      .in_valid_i           (in_valid),
      .in_ready_o           (in_ready),
      .out_data_o           (out_data),
      .out_valid_o          (out_valid),
      .out_ready_i          (out_ready),
      .acc_output_success_o (success),
      .pe_idle_o            (pe_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Inputs only change just after posedge, so a success seen at negedge is
   // the transfer that happens on the next posedge.
   always @(negedge clk) begin
      if (!rst && success) begin
         out_q.push_back(out_data);
         out_cyc.push_back(cycle);
      end
   end

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [2*W-1:0] d, output int stalls);
      int n;
      stalls   = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) break;
         stalls++;
         @(posedge clk);
         #1;
      end
      if (n == 50) begin
         check("push_timeout", 64'd1, 64'd0);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_q(input int n);
      int k;
      for (k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (out_q.size() >= n) break;
      end
      if (k == 100) check("output_timeout", 64'(out_q.size()), 64'(n));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      logic [W-1:0]   up;
      logic [W-1:0]   lo;
      logic [2*W-1:0] din;
      logic [2*W-1:0] exp_wrap;
      logic [2*W-1:0] exp_sat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int st;
      int base;
      int stall_total;
      logic [2*W-1:0] held;
      logic [2*W-1:0] e;

      vecs[0] = '{32'h1, 32'h10, 64'h0000_0000_0000_0005,
                  64'h0000_0001_0000_0015, 64'h0000_0001_0000_0015};
      vecs[1] = '{32'h0, 32'h2, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{32'h0, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001,
                  64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};
      vecs[3] = '{32'hFFFF_FFFF, 32'h0, 64'h0000_0001_0000_0000,
                  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h1111_1111_1111_1111,
                  64'h2345_6789_ABCD_F001, 64'h2345_6789_ABCD_F001};
      vecs[5] = '{32'h0, 32'h0, 64'hDEAD_BEEF_0BAD_F00D,
                  64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D};

      rst        = 1'b1;
      acc_ready  = 1'b0;
      upper_bias = '0;
      lower_bias = '0;
      in_data    = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;

      // Reset state
      idle_cycles(2);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_success", 64'(success), 64'd0);
      check("rst_pe_idle", 64'(pe_idle), 64'd1);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      acc_ready = 1'b1;
      out_ready = 1'b1;
      idle_cycles(1);

      // Single-word vectors with latency check
      foreach (vecs[i]) begin
`ifdef SNAX_EXERCISE_BIAS_PE_SAT_EN
         e = vecs[i].exp_sat;
`else
         e = vecs[i].exp_wrap;
`endif
         upper_bias = vecs[i].up;
         lower_bias = vecs[i].lo;
         base = out_q.size();
         push_word(vecs[i].din, st);
         @(negedge clk);
         check($sformatf("vec%0d_lat1_valid", i), 64'(out_valid), 64'd0);
         @(negedge clk);
         check($sformatf("vec%0d_lat2_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d_data", i), out_data, e);
         idle_cycles(3);
         check($sformatf("vec%0d_pulses", i), 64'(out_q.size() - base), 64'd1);
         check($sformatf("vec%0d_idle", i), 64'(pe_idle), 64'd1);
      end

      // Streaming 0..7 with bias 2
      upper_bias = 32'h0;
      lower_bias = 32'h2;
      base = out_q.size();
      stall_total = 0;
      for (int i = 0; i < 8; i++) begin
         push_word(64'(i), st);
         stall_total += st;
      end
      wait_q(base + 8);
      check("stream_stalls", 64'(stall_total), 64'd0);
      check("stream_count", 64'(out_q.size() - base), 64'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("stream_data%0d", i), out_q[base + i], 64'(i + 2));
      check("stream_consecutive", 64'(out_cyc[base + 7] - out_cyc[base]), 64'd7);
      idle_cycles(2);

      // Backpressure: two words fill the pipe, the third is refused
      out_ready = 1'b0;
      base = out_q.size();
      push_word(64'h100, st);
      push_word(64'h200, st);
      in_valid = 1'b1;
      in_data  = 64'h300;
      @(negedge clk);
      held = out_data;
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_first_data", held, 64'h102);
      repeat (3) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("bp_data_stable", out_data, held);
         check("bp_in_ready_held", 64'(in_ready), 64'd0);
      end
      check("bp_no_pulse", 64'(out_q.size() - base), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_word(64'h300, st);
      wait_q(base + 3);
      check("bp_out0", out_q[base], 64'h102);
      check("bp_out1", out_q[base + 1], 64'h202);
      check("bp_out2", out_q[base + 2], 64'h302);
      idle_cycles(3);

      // Bias change between two consecutive accepts
      base = out_q.size();
      upper_bias = 32'h0;
      lower_bias = 32'h1;
      push_word(64'h10, st);
      lower_bias = 32'h100;
      push_word(64'h10, st);
      wait_q(base + 2);
      check("bias_chg_a", out_q[base], 64'h11);
      check("bias_chg_b", out_q[base + 1], 64'h110);
      idle_cycles(3);

      // acc_ready drop with two words in flight
      out_ready = 1'b0;
      upper_bias = 32'h0;
      lower_bias = 32'h0;
      base = out_q.size();
      push_word(64'hA, st);
      push_word(64'hB, st);
      acc_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hC;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("en_in_ready_low", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      check("en_pulses", 64'(out_q.size() - base), 64'd2);
      check("en_drain0", out_q[base], 64'hA);
      check("en_drain1", out_q[base + 1], 64'hB);
      check("en_idle", 64'(pe_idle), 64'd1);
      in_valid  = 1'b0;
      acc_ready = 1'b1;
      idle_cycles(2);

      // Asynchronous reset with a full pipeline
      out_ready = 1'b0;
      base = out_q.size();
      push_word(64'h55, st);
      push_word(64'h66, st);
      @(negedge clk);
      check("rstm_full_idle", 64'(pe_idle), 64'd0);
      check("rstm_full_valid", 64'(out_valid), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rstm_out_valid", 64'(out_valid), 64'd0);
      check("rstm_pe_idle", 64'(pe_idle), 64'd1);
      check("rstm_out_data", out_data, 64'd0);
      out_ready = 1'b1;
      #1;
      check("rstm_success", 64'(success), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycles(4);
      check("rstm_no_pulse", 64'(out_q.size() - base), 64'd0);
      check("rstm_idle_after", 64'(pe_idle), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/snax_exercise_bias_pe.md
Name: snax_exercise_bias_pe

Overview:
- Streaming bias-add processing element that sits directly downstream of the exercise CSR block.
- Consumes 64-bit words from the read streamer and adds the 64-bit bias {csr_upper_bias, csr_lower_bias} to each word.
- Emits results to the write streamer through a 2-stage valid/ready pipeline.
- Returns a one-cycle success pulse per word written, which the CSR block counts against its programmed length.

Parameters:
- RegDataWidth, 32, width of each bias half; the datapath is 2*RegDataWidth bits wide.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- acc_ready_i  in  1  CSR busy/enable; input acceptance only while high
- csr_upper_bias_i  in  RegDataWidth  bias bits [2W-1:W]
- csr_lower_bias_i  in  RegDataWidth  bias bits [W-1:0]
- in_data_i  in  2*RegDataWidth  operand word from read streamer
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  operand accepted when in_valid_i && in_ready_o
- out_data_o  out  2*RegDataWidth  result word to write streamer
- out_valid_o  out  1  result valid
- out_ready_i  in  1  write streamer ready
- acc_output_success_o  out  1  one-cycle pulse = out_valid_o && out_ready_i
- pe_idle_o  out  1  high when both pipeline stages are empty

Behaviour:
- Reset (async assert, clk-synchronous release):
  - s1_valid = s2_valid = 0; all data and bias registers = 0.
  - out_valid_o = 0, out_data_o = 0, acc_output_success_o = 0 (combinational, so also 0), pe_idle_o = 1.
- Stage 1 (capture):
  - Registers in_data_i, together with a snapshot of {upper, lower} bias taken in the same cycle.
  - A bias change therefore affects only words accepted after that change.
- Stage 2 (result):
  - Registers s1_data + s1_bias, modulo 2^(2W); the carry out is dropped.
  - Drives out_data_o and out_valid_o directly from the register, with no combinational path from in_* to out_*.
- Advance rules:
  - s2_adv = !s2_valid || out_ready_i
  - s1_adv = !s1_valid || (s1_valid && s2_adv)
  - in_ready_o = acc_ready_i && s1_adv; it depends on out_ready_i combinationally, which is allowed.
  - s2 loads when s1_valid && s2_adv. s2_valid clears when it is consumed and s1 is empty.
  - s1 loads on an input handshake. s1_valid clears when it moves to s2 and no new input arrives.
- Latency and throughput:
  - Word accepted at edge N appears on out_valid_o after edge N+1, i.e. 2 cycles from in_valid_i.
  - Full throughput is 1 word/cycle with out_ready_i held high.
- Backpressure:
  - With out_ready_i low, the pipeline holds up to 2 words. in_ready_o drops once s1 and s2 are both full.
  - out_data_o is stable while out_valid_o && !out_ready_i.
- acc_ready_i low:
  - New input is blocked (in_ready_o = 0).
  - In-flight words still drain normally and still generate success pulses.
- Simultaneous events: input accept, s1→s2 move and output consume may all occur in the same cycle with no bubble.
- Reset mid-operation: all in-flight words are discarded and no success pulse is generated for them.
- pe_idle_o = !s1_valid && !s2_valid.

Optional Feature:
- Macro: SNAX_EXERCISE_BIAS_PE_SAT_EN.
- Defined: stage-2 addition is unsigned-saturating. When the (2W+1)-bit sum carries out, the result is all ones (0xFFFF_FFFF_FFFF_FFFF for W=32).
- Undefined: wrap-around modulo 2^(2W) as described above. Ports and timing are identical in both builds.

Test Plan:
- Basic add:
  - Stimulus: bias upper=0x1, lower=0x10; acc_ready_i=1; single input 0x0000_0000_0000_0005; out_ready_i=1.
  - Response: out_data_o=0x0000_0001_0000_0015 two cycles later, with exactly one success pulse.
- Streaming:
  - Stimulus: 8 back-to-back inputs 0..7; bias=0x2; out_ready_i=1.
  - Response: outputs 2..9 on 8 consecutive cycles; 8 success pulses; in_ready_o never drops.
- Backpressure:
  - Stimulus: out_ready_i=0 while 3 inputs are offered.
  - Response: 2 inputs accepted, in_ready_o=0 on the third; out_data_o stable. Releasing out_ready_i delivers all 3 in order.
- Bias change mid-stream:
  - Stimulus: word A=0x10 accepted with bias 0x1; bias changes to 0x100 the following cycle; word B=0x10 accepted.
  - Response: outputs 0x11 then 0x110.
- Enable and reset:
  - Stimulus: acc_ready_i drops with 2 words in flight.
  - Response: both drain with 2 success pulses; in_ready_o=0; pe_idle_o=1 afterwards.
  - Stimulus: rst_i asserted with a full pipeline.
  - Response: out_valid_o=0 immediately, pe_idle_o=1, no pulse.
- Overflow:
  - Stimulus: input 0xFFFF_FFFF_FFFF_FFFF with bias 0x2.
  - Response: output 0x1 without the macro; 0xFFFF_FFFF_FFFF_FFFF with SNAX_EXERCISE_BIAS_PE_SAT_EN defined.
